// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// cache_mem_arbiter : round-robin backing-memory arbiter + CPU stall/clock-enable
// Rev 1.0
// ============================================================================
module cache_mem_arbiter #(
  parameter int NPORT = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [NPORT-1:0]    req_en,
  input  logic [NPORT-1:0]    req_hit,
  input  logic [NPORT-1:0]    c_req,
  input  logic [NPORT-1:0]    c_we,
  input  logic [NPORT*AW-1:0] c_addr,
  input  logic [NPORT*DW-1:0] c_wd,
  output logic [NPORT-1:0]    c_ready,
  output logic [DW-1:0]       c_rd,
  output logic                m_req,
  output logic                m_we,
  output logic [AW-1:0]       m_addr,
  output logic [DW-1:0]       m_wd,
  input  logic                m_ready,
  input  logic [DW-1:0]       m_rd,
  output logic [NPORT-1:0]    grant,
  output logic                stall,
  output logic                cpu_en
);

  localparam int               c_IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam logic [0:0]       c_IDLE  = 1'b0;
  localparam logic [0:0]       c_BUSY  = 1'b1;
  localparam logic [NPORT-1:0] c_ONE   = NPORT'(1);

  logic [0:0]         r_state;
  logic [NPORT-1:0]   r_grant;
  logic [c_IDX_W-1:0] r_owner;
  logic [c_IDX_W-1:0] r_last;
  logic               r_mWe;
  logic [AW-1:0]      r_mAddr;
  logic [DW-1:0]      r_mWd;
  logic               r_readyQ;

  logic               w_found;
  logic [c_IDX_W-1:0] w_sel;
  logic               w_stall;
  logic               w_done;

  // Search starts just after the last owner so every requester is reached
  // within NPORT-1 foreign transactions.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 1; k <= NPORT; k++) begin
      if (!w_found && c_req[(int'(r_last) + k) % NPORT]) begin
        w_found = 1'b1;
        w_sel   = c_IDX_W'((int'(r_last) + k) % NPORT);
      end
    end
  end

  assign w_done  = (r_state == c_BUSY) && m_ready;
  assign w_stall = |(req_en & ~req_hit);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state  <= c_IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_last   <= c_IDX_W'(NPORT - 1);
      r_mWe    <= 1'b0;
      r_mAddr  <= '0;
      r_mWd    <= '0;
      r_readyQ <= 1'b0;
    end else begin
      r_readyQ <= ~w_stall;
      case (r_state)
        c_IDLE: begin
          if (w_found) begin
            r_state <= c_BUSY;
            r_grant <= c_ONE << w_sel;
            r_owner <= w_sel;
            r_mWe   <= c_we[w_sel];
            r_mAddr <= c_addr[int'(w_sel)*AW +: AW];
            r_mWd   <= c_wd[int'(w_sel)*DW +: DW];
          end
        end
        default: begin
          if (m_ready) begin
            r_state <= c_IDLE;
            r_grant <= '0;
            r_last  <= r_owner;
          end
        end
      endcase
    end
  end

  // Completion is combinational so the requester sees data in the m_ready cycle.
  assign c_ready = (w_done && !Reset) ? r_grant : '0;
  assign c_rd    = m_rd;
  assign m_req   = (r_state == c_BUSY);
  assign m_we    = r_mWe;
  assign m_addr  = r_mAddr;
  assign m_wd    = r_mWd;
  assign grant   = r_grant;
  assign stall   = w_stall;
  assign cpu_en  = ~w_stall & r_readyQ;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_cache_mem_arbiter : directed bench with a per-cycle behavioural model
// Rev 1.0
// ============================================================================
module tb_cache_mem_arbiter;

  localparam int NPORT = 2;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic                CLK = 1'b0;
  logic                Reset;
  logic [NPORT-1:0]    reqEn, reqHit, cReq, cWe;
  logic [NPORT*AW-1:0] cAddr;
  logic [NPORT*DW-1:0] cWd;
  logic                mReady;
  logic [DW-1:0]       mRd;
  logic [NPORT-1:0]    cReady, grant;
  logic [DW-1:0]       cRd, mWd;
  logic [AW-1:0]       mAddr;
  logic                mReq, mWe, stall, cpuEn;

  cache_mem_arbiter #(.NPORT(NPORT), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .Reset(Reset), .req_en(reqEn), .req_hit(reqHit),
    .c_req(cReq), .c_we(cWe), .c_addr(cAddr), .c_wd(cWd),
    .c_ready(cReady), .c_rd(cRd), .m_req(mReq), .m_we(mWe),
    .m_addr(mAddr), .m_wd(mWd), .m_ready(mReady), .m_rd(mRd),
    .grant(grant), .stall(stall), .cpu_en(cpuEn)
  );

  always #5 CLK = ~CLK;

  int nVec = 0;
  int nErr = 0;

  // Model of the arbiter: who owns memory, who went last, latched request.
  bit            mdBusy   = 0;
  int            mdOwner  = 0;
  int            mdLast   = NPORT - 1;
  bit            mdWe     = 0;
  logic [AW-1:0] mdAddr   = '0;
  logic [DW-1:0] mdWd     = '0;
  bit            mdPrevOk = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare all outputs against the model, then advance the model past the
  // coming clock edge and wait for the next drive point.
  task automatic cycle();
    logic [NPORT-1:0] eGrant, eReady;
    bit eStall, eEn;
    int best, bestDist;
    #1;
    eGrant = '0;
    if (mdBusy) eGrant[mdOwner] = 1'b1;
    eReady = (mdBusy && mReady && !Reset) ? eGrant : '0;
    eStall = |(reqEn & ~reqHit);
    eEn    = !eStall && mdPrevOk;
    cmp("grant",   64'(grant),   64'(eGrant));
    cmp("m_req",   64'(mReq),    64'(mdBusy));
    cmp("m_we",    64'(mWe),     64'(mdWe));
    cmp("m_addr",  64'(mAddr),   64'(mdAddr));
    cmp("m_wd",    64'(mWd),     64'(mdWd));
    cmp("c_ready", 64'(cReady),  64'(eReady));
    cmp("stall",   64'(stall),   64'(eStall));
    cmp("cpu_en",  64'(cpuEn),   64'(eEn));
    if (eReady != '0) cmp("c_rd", 64'(cRd), 64'(mRd));

    if (Reset) begin
      mdBusy = 0; mdLast = NPORT - 1; mdWe = 0; mdAddr = '0; mdWd = '0; mdPrevOk = 0;
    end else begin
      mdPrevOk = !eStall;
      if (!mdBusy) begin
        // Winner is the requester closest after the last owner, circularly.
        best = -1; bestDist = NPORT;
        for (int p = 0; p < NPORT; p++) begin
          int d;
          d = (p - mdLast - 1 + 2*NPORT) % NPORT;
          if (cReq[p] && d < bestDist) begin best = p; bestDist = d; end
        end
        if (best >= 0) begin
          mdBusy = 1; mdOwner = best; mdWe = cWe[best];
          mdAddr = cAddr[best*AW +: AW]; mdWd = cWd[best*DW +: DW];
        end
      end else if (mReady) begin
        mdLast = mdOwner; mdBusy = 0;
      end
    end
    @(negedge CLK);
  endtask

  logic [NPORT-1:0] order [4];
  logic [NPORT-1:0] expOrder [4];

  initial begin
    Reset = 1; reqEn = '0; reqHit = '0; cReq = '0; cWe = '0;
    cAddr = '0; cWd = '0; mReady = 0; mRd = '0;
    expOrder[0] = 2'b01; expOrder[1] = 2'b10; expOrder[2] = 2'b01; expOrder[3] = 2'b10;
    @(negedge CLK);

    // 1: reset
    cycle(); cycle();
    #1;
    cmp("rst_grant", 64'(grant), 64'd0);
    cmp("rst_mreq", 64'(mReq), 64'd0);
    cmp("rst_cpuen", 64'(cpuEn), 64'd0);
    cycle();
    Reset = 0;
    #1; cmp("rel_cpuen0", 64'(cpuEn), 64'd0);
    cycle();
    #1; cmp("rel_cpuen1", 64'(cpuEn), 64'd1);
    cycle();

    // 2: single read from port 0
    cReq = 2'b01; cAddr = {32'h0, 32'h40};
    cycle();
    #1;
    cmp("t2_mreq", 64'(mReq), 64'd1);
    cmp("t2_addr", 64'(mAddr), 64'h40);
    cycle(); cycle();
    mReady = 1; mRd = 32'hDEADBEEF; cReq = 2'b00;
    #1;
    cmp("t2_cready", 64'(cReady), 64'd1);
    cmp("t2_crd", 64'(cRd), 64'hDEADBEEF);
    cycle();
    mReady = 0; mRd = '0;
    #1; cmp("t2_grant0", 64'(grant), 64'd0);
    cycle();

    // 3: both ports requesting from reset alternate
    Reset = 1; cycle(); Reset = 0;
    cReq = 2'b11; cAddr = {32'h200, 32'h100};
    for (int t = 0; t < 4; t++) begin
      cycle();
      cycle();
      mReady = 1; mRd = 32'(t + 1);
      #1; order[t] = cReady;
      cycle();
      mReady = 0; mRd = '0;
    end
    cReq = 2'b00;
    for (int t = 0; t < 4; t++) cmp("t3_order", 64'(order[t]), 64'(expOrder[t]));
    cycle();

    // 4: miss on port 1 for four cycles
    reqEn = 2'b10; reqHit = 2'b00;
    for (int t = 0; t < 4; t++) begin
      #1;
      cmp("t4_stall", 64'(stall), 64'd1);
      cmp("t4_cpuen", 64'(cpuEn), 64'd0);
      cycle();
    end
    reqHit = 2'b10;
    #1;
    cmp("t4_stall0", 64'(stall), 64'd0);
    cmp("t4_settle", 64'(cpuEn), 64'd0);
    cycle();
    #1; cmp("t4_cpuen1", 64'(cpuEn), 64'd1);
    cycle();
    reqEn = 2'b00; reqHit = 2'b00;

    // 5: port 1 write with request dropped mid-transaction
    cReq = 2'b10; cWe = 2'b10; cAddr = {32'h80, 32'h0}; cWd = {32'h1234, 32'h0};
    cycle();
    cReq = 2'b00;
    #1;
    cmp("t5_we", 64'(mWe), 64'd1);
    cmp("t5_wd", 64'(mWd), 64'h1234);
    cmp("t5_addr", 64'(mAddr), 64'h80);
    cycle(); cycle();
    mReady = 1;
    #1; cmp("t5_cready", 64'(cReady), 64'b10);
    cycle();
    mReady = 0; cWe = 2'b00;
    cycle();

    // 6: reset during a transaction
    cReq = 2'b10;
    cycle();
    #1; cmp("t6_grant1", 64'(grant), 64'b10);
    cycle();
    Reset = 1;
    cycle();
    Reset = 0; cReq = 2'b11; mReady = 1;
    #1;
    cmp("t6_mreq0", 64'(mReq), 64'd0);
    cmp("t6_grant0", 64'(grant), 64'd0);
    cmp("t6_cready0", 64'(cReady), 64'd0);
    cycle();
    mReady = 0;
    #1; cmp("t6_port0", 64'(grant), 64'b01);
    cycle();
    mReady = 1; cycle();
    mReady = 0; cReq = 2'b00;
    cycle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
`default_nettype wire
